stall_mem_responder: RTL and testbench
======================================

Name: stall_mem_responder

Overview:
- Multi-cycle data-memory responder for the memory stage. Sits on the far side of the memory stage's data-memory request interface: addr, data_in, enable, wr.
- Accepts one request at a time and latches it. Holds the requester with `stall` for a fixed latency, then completes the access and pulses `done` with read data.
- Replaces the single-cycle data memory when slow-memory stall behaviour must be exercised in the pipeline.

Parameters:
- DEPTH_LOG2, 8, log2 of memory depth in 16-bit words (256 words).
- LATENCY, 3, cycles from request acceptance to `done`; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- addr  input  16  byte address; bit 0 must be 0.
- data_in  input  16  write data.
- enable  input  1  request valid (read or write).
- wr  input  1  1 = write, 0 = read; meaningful only with enable.
- data_out  output  16  read data, registered.
- stall  output  1  requester must hold the pipeline this cycle.
- done  output  1  one-cycle completion pulse, registered.
- err  output  1  unaligned request flag, combinational.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, counter=0, data_out=0, done=0, latched request cleared.
  - Memory array is not cleared; contents are undefined until written.
  - stall=0 and err=0 while in reset.
- Word index is addr[DEPTH_LOG2:1]. Address bits above that are ignored, so addresses wrap modulo 2*2^DEPTH_LOG2 bytes.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If enable=1 and addr[0]=0, the request is accepted: latch addr, data_in, wr; load counter=LATENCY-1.
  - Next state is DONE if LATENCY=1, otherwise BUSY.
  - If enable=1 and addr[0]=1: err=1 in that cycle, stall=0, no access, stay IDLE.
  - If enable=0: stay IDLE.
- BUSY:
  - Decrement counter each cycle.
  - When counter==1 at the clock edge, next state is DONE.
  - Input changes during BUSY are ignored; the latched request is used.
- Entering DONE (clock edge):
  - Write: mem[latched index] <= latched data; data_out holds its previous value.
  - Read: data_out <= mem[latched index].
- DONE:
  - done=1 for exactly one cycle; next state is always IDLE.
  - No request is accepted in DONE, even if enable is still high.
- stall (combinational) = (state==IDLE & enable & ~addr[0]) | state==BUSY.
  - stall is 0 in DONE, so the requester advances on the edge that ends the DONE cycle.
- err (combinational) = state==IDLE & enable & addr[0]. err is 0 in BUSY and DONE.
- Timing: request seen in cycle 0 → done=1 and data_out valid in cycle LATENCY. A new request can be accepted in cycle LATENCY+1 at the earliest.
- Back-to-back same address: a read after a write returns the written data, because the write commits on entry to DONE, before the next accept.
- Reset mid-operation: any BUSY access is abandoned, with no memory write and no done pulse. The FSM is in IDLE on the first edge after rst releases.
- data_out changes only on read completion or reset.

Test Plan:
- Reset, then write addr=0x0010, data_in=0xBEEF, enable=1, wr=1 held → stall=1 in cycles 0–2, done=1 and stall=0 in cycle 3, no other done pulses.
- Read addr=0x0010 afterwards → data_out=0xBEEF with done in cycle 3. Then read addr=0x0210 (DEPTH_LOG2=8 wrap) → data_out=0xBEEF.
- Unaligned read addr=0x0011, enable=1 → err=1, stall=0, done never asserts, state stays IDLE, data_out unchanged.
- Change addr to 0x0020 and data_in to 0x1234 during BUSY of a write to 0x0030 with data 0x5555 → read 0x0030 returns 0x5555; 0x0020 is unchanged.
- Assert rst low during BUSY of a write 0x00AA→0x0040 → done=0, stall=0, data_out=0 immediately; a later read of 0x0040 does not return 0x00AA (pre-write 0x1111 retained).
- LATENCY=1 build: consecutive reads of two preloaded words 0x0002=0x0A0A and 0x0004=0x0B0B → done in cycles 1 and 3, stall high only in cycles 0 and 2, data_out 0x0A0A then 0x0B0B.

Source files
------------

// File: rtl/stall_mem_responder.sv
// ---------------------------------------------------------------------------
// stall_mem_responder
//
// Multi-cycle data memory for the memory stage. It accepts one aligned request
// at a time, latches it, and holds the requester with `stall` for LATENCY
// cycles. It then performs the access and pulses `done`. Read data appears on
// `data_out` in the same cycle as `done`.
//
// Parameters
//   DEPTH_LOG2 : log2 of memory depth in 16-bit words
//   LATENCY    : cycles from request acceptance to done (1..15)
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   addr      : byte address; bit 0 must be 0
//   data_in   : write data
//   enable    : request valid (read or write)
//   wr        : 1 = write, 0 = read; meaningful only with enable
//   data_out  : registered read data; changes only on read completion/reset
//   stall     : requester must hold the pipeline this cycle (combinational)
//   done      : registered one-cycle completion pulse
//   err       : unaligned request flag (combinational)
//   state_dbg : current FSM state (IDLE=0, BUSY=1, DONE=2) for observation
//
// Handshake: a request is offered by holding enable high with a stable
// addr/data_in/wr. It is taken on a clock edge in IDLE while addr[0]=0, and
// stall is high in that same cycle. While stall is high the requester keeps
// the pipeline frozen. In the DONE cycle stall drops, done pulses, and the
// requester advances on the edge that ends DONE. Because DONE never accepts,
// the earliest next request is taken one cycle after done.
// ---------------------------------------------------------------------------
module stall_mem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   input  logic        enable,
   input  logic        wr,
   output logic [15:0] data_out,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state, state_next;
   logic [3:0]            counter;
   logic [DEPTH_LOG2-1:0] lat_idx;
   logic [15:0]           lat_data;
   logic                  lat_wr;
   logic [15:0]           mem [0:(1<<DEPTH_LOG2)-1];

   logic                  accept;
   logic                  enter_done;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic [15:0]           acc_data;
   logic                  acc_wr;

   // Address bits above the word index are ignored, so the memory wraps.
   logic                  unused_addr_hi;
   assign unused_addr_hi = &{1'b0, addr[15:DEPTH_LOG2+1]};

   // rst gates accept so that nothing is accepted or written while reset is
   // held, even with enable high.
   assign accept     = rst & (state == IDLE) & enable & ~addr[0];
   assign enter_done = (state_next == DONE) && (state != DONE);

   // With LATENCY=1 the FSM jumps from IDLE straight to DONE. The latch is
   // loaded on that same edge, so the access must use the live inputs.
   always_comb begin
      if (state == IDLE) begin
         acc_idx  = addr[DEPTH_LOG2:1];
         acc_data = data_in;
         acc_wr   = wr;
      end else begin
         acc_idx  = lat_idx;
         acc_data = lat_data;
         acc_wr   = lat_wr;
      end
   end

   // ---- FSM: state register ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // ---- FSM: next-state logic ----
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = (LATENCY == 1) ? DONE : BUSY;
         BUSY:    if (counter == 4'd1) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---- FSM: combinational outputs ----
   always_comb begin
      stall     = 1'b0;
      err       = 1'b0;
      state_dbg = state;
      case (state)
         IDLE: begin
            stall = accept;
            err   = rst & enable & addr[0];
         end
         BUSY:    stall = 1'b1;
         default: ;
      endcase
   end

   // Request latch and latency counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         counter  <= '0;
         lat_idx  <= '0;
         lat_data <= '0;
         lat_wr   <= 1'b0;
      end else if (accept) begin
         counter  <= 4'(LATENCY - 1);
         lat_idx  <= addr[DEPTH_LOG2:1];
         lat_data <= data_in;
         lat_wr   <= wr;
      end else if (state == BUSY) begin
         counter  <= counter - 4'd1;
      end
   end

   // Completion pulse and read data, both set on entry to DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done     <= 1'b0;
         data_out <= '0;
      end else begin
         done <= enter_done;
         if (enter_done && !acc_wr) data_out <= mem[acc_idx];
      end
   end

   // Storage array is not reset. A reset during BUSY forces IDLE at once, so
   // enter_done stays low and the abandoned write never reaches the array.
   always_ff @(posedge clk) begin
      if (enter_done && acc_wr) mem[acc_idx] <= acc_data;
   end

endmodule

// File: tb/tb_stall_mem_responder.sv
// ---------------------------------------------------------------------------
// Testbench for stall_mem_responder. Two instances run side by side:
//   dut_a : LATENCY=3 (default build)
//   dut_b : LATENCY=1
// The reference model is a plain word array indexed by (addr/2) mod 256. The
// expected stall/done timing comes straight from the latency rule: stall in
// cycles 0..L-1, done in cycle L.
// ---------------------------------------------------------------------------
module tb_stall_mem_responder;

   localparam int LAT_A = 3;
   localparam int LAT_B = 1;

   logic        clk;
   logic        rst_a, en_a, wr_a, stall_a, done_a, err_a;
   logic [15:0] addr_a, din_a, dout_a;
   logic [1:0]  st_a;
   logic        rst_b, en_b, wr_b, stall_b, done_b, err_b;
   logic [15:0] addr_b, din_b, dout_b;
   logic [1:0]  st_b;

   int cmp = 0;
   int mis = 0;

   // Reference model for dut_a.
   logic [15:0] model_mem   [256];
   bit          model_known [256];
   logic [15:0] exp_dout;
   bit          dout_known;

   stall_mem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT_A)) dut_a (
      .clk(clk), .rst(rst_a), .addr(addr_a), .data_in(din_a), .enable(en_a),
      .wr(wr_a), .data_out(dout_a), .stall(stall_a), .done(done_a),
      .err(err_a), .state_dbg(st_a)
   );

   stall_mem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT_B)) dut_b (
      .clk(clk), .rst(rst_b), .addr(addr_b), .data_in(din_b), .enable(en_b),
      .wr(wr_b), .data_out(dout_b), .stall(stall_b), .done(done_b),
      .err(err_b), .state_dbg(st_b)
   );

   // ---- clock ----
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One access on dut_a, started #1 after a rising edge. It ends #1 after
   // the edge that closes the done cycle, with enable already dropped.
   // When scr=1, the inputs are changed to scr_* after the accept edge.
   task automatic access_a(input logic [15:0] a, input logic [15:0] d,
                           input logic w, input bit hold, input bit scr,
                           input logic [15:0] scr_addr,
                           input logic [15:0] scr_data, input logic scr_wr);
      int          idx;
      logic [15:0] rd_val;
      bit          rd_known;
      idx      = (int'(a) / 2) % 256;
      rd_val   = model_mem[idx];
      rd_known = model_known[idx];
      addr_a = a; din_a = d; wr_a = w; en_a = 1'b1;
      for (int c = 0; c <= LAT_A; c++) begin
         @(negedge clk);
         cmp++;
         if (stall_a !== 1'(c < LAT_A)) begin
            mis++;
            $display("FAIL access_stall addr=%h c=%0d got %b exp %b", a, c, stall_a, c < LAT_A);
         end
         cmp++;
         if (done_a !== 1'(c == LAT_A)) begin
            mis++;
            $display("FAIL access_done addr=%h c=%0d got %b exp %b", a, c, done_a, c == LAT_A);
         end
         cmp++;
         if (err_a !== 1'b0) begin
            mis++;
            $display("FAIL access_err addr=%h c=%0d got %b exp 0", a, c, err_a);
         end
         if (c == LAT_A) begin
            if (w) begin
               model_mem[idx]   = d;
               model_known[idx] = 1'b1;
            end else begin
               exp_dout   = rd_val;
               dout_known = rd_known;
            end
            if (dout_known) begin
               cmp++;
               if (dout_a !== exp_dout) begin
                  mis++;
                  $display("FAIL access_data addr=%h wr=%b got %h exp %h", a, w, dout_a, exp_dout);
               end
            end
         end
         @(posedge clk); #1;
         if (c == 0 && !hold) en_a = 1'b0;
         if (c == 0 && scr) begin
            addr_a = scr_addr; din_a = scr_data; wr_a = scr_wr;
         end
      end
      en_a = 1'b0;
   endtask

   task automatic idle_a(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst_a = 1'b0; rst_b = 1'b0;
      en_a = 1'b0; wr_a = 1'b0; addr_a = '0; din_a = '0;
      en_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;
      repeat (2) @(negedge clk);
      cmp++; if (dout_a !== 16'h0) begin mis++; $display("FAIL reset_dout got %h exp 0000", dout_a); end
      cmp++; if (done_a !== 1'b0)  begin mis++; $display("FAIL reset_done got %b exp 0", done_a); end
      cmp++; if (stall_a !== 1'b0) begin mis++; $display("FAIL reset_stall got %b exp 0", stall_a); end
      cmp++; if (st_a !== 2'd0)    begin mis++; $display("FAIL reset_state got %0d exp 0", st_a); end
      cmp++; if (dout_b !== 16'h0) begin mis++; $display("FAIL reset_dout_b got %h exp 0000", dout_b); end
      // Requests offered while reset is held must not stall or flag.
      en_a = 1'b1; addr_a = 16'h0010; wr_a = 1'b1;
      en_b = 1'b1; addr_b = 16'h0011;
      @(negedge clk);
      cmp++; if (stall_a !== 1'b0) begin mis++; $display("FAIL reset_req_stall got %b exp 0", stall_a); end
      cmp++; if (err_b !== 1'b0)   begin mis++; $display("FAIL reset_req_err got %b exp 0", err_b); end
      en_a = 1'b0; en_b = 1'b0; wr_a = 1'b0;
      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1;
      exp_dout = 16'h0; dout_known = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read_wrap;
      // Write held with enable high through done, then aligned reads.
      access_a(16'h0010, 16'hBEEF, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      cmp++; if (done_a !== 1'b0) begin mis++; $display("FAIL extra_done got %b exp 0", done_a); end
      @(posedge clk); #1;
      access_a(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      access_a(16'h0210, 16'h0000, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic test_unaligned;
      en_a = 1'b1; addr_a = 16'h0011; wr_a = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         cmp++; if (err_a !== 1'b1)    begin mis++; $display("FAIL unal_err c=%0d got %b exp 1", c, err_a); end
         cmp++; if (stall_a !== 1'b0)  begin mis++; $display("FAIL unal_stall c=%0d got %b exp 0", c, stall_a); end
         cmp++; if (done_a !== 1'b0)   begin mis++; $display("FAIL unal_done c=%0d got %b exp 0", c, done_a); end
         cmp++; if (st_a !== 2'd0)     begin mis++; $display("FAIL unal_state c=%0d got %0d exp 0", c, st_a); end
         cmp++; if (dout_a !== exp_dout) begin mis++; $display("FAIL unal_dout c=%0d got %h exp %h", c, dout_a, exp_dout); end
         @(posedge clk); #1;
      end
      en_a = 1'b0;
      idle_a(1);
   endtask

   task automatic test_busy_ignore;
      access_a(16'h0020, 16'h7777, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      access_a(16'h0030, 16'h5555, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1);
      access_a(16'h0030, 16'h0000, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      access_a(16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic test_reset_mid_op;
      access_a(16'h0040, 16'h1111, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      addr_a = 16'h0040; din_a = 16'h00AA; wr_a = 1'b1; en_a = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      cmp++; if (stall_a !== 1'b1) begin mis++; $display("FAIL midrst_busy got %b exp 1", stall_a); end
      rst_a = 1'b0;
      #1;
      cmp++; if (done_a !== 1'b0)   begin mis++; $display("FAIL midrst_done got %b exp 0", done_a); end
      cmp++; if (stall_a !== 1'b0)  begin mis++; $display("FAIL midrst_stall got %b exp 0", stall_a); end
      cmp++; if (dout_a !== 16'h0)  begin mis++; $display("FAIL midrst_dout got %h exp 0000", dout_a); end
      exp_dout = 16'h0; dout_known = 1'b1;
      en_a = 1'b0;
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      @(posedge clk); #1;
      cmp++; if (st_a !== 2'd0)   begin mis++; $display("FAIL midrst_idle got %0d exp 0", st_a); end
      cmp++; if (done_a !== 1'b0) begin mis++; $display("FAIL midrst_nodone got %b exp 0", done_a); end
      access_a(16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         logic [15:0] a, d, sa, sd;
         int          word, upper;
         word  = int'($urandom_range(0, 15));
         upper = int'($urandom_range(0, 127));
         a     = 16'(upper * 512 + word * 2);
         d     = 16'($urandom);
         sa    = 16'($urandom);
         sd    = 16'($urandom);
         access_a(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), sa, sd, 1'($urandom_range(0, 1)));
         idle_a(int'($urandom_range(0, 2)));
      end
   endtask

   // Two writes, then two back-to-back reads on the LATENCY=1 build.
   task automatic test_latency1;
      logic [15:0] pa [2];
      logic [15:0] pd [2];
      pa[0] = 16'h0002; pd[0] = 16'h0A0A;
      pa[1] = 16'h0004; pd[1] = 16'h0B0B;
      for (int k = 0; k < 2; k++) begin
         addr_b = pa[k]; din_b = pd[k]; wr_b = 1'b1; en_b = 1'b1;
         @(negedge clk);
         cmp++; if (stall_b !== 1'b1) begin mis++; $display("FAIL lat1_wstall k=%0d got %b exp 1", k, stall_b); end
         @(posedge clk); #1;
         en_b = 1'b0;
         @(negedge clk);
         cmp++; if (done_b !== 1'b1) begin mis++; $display("FAIL lat1_wdone k=%0d got %b exp 1", k, done_b); end
         @(posedge clk); #1;
      end
      addr_b = pa[0]; wr_b = 1'b0; en_b = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         cmp++;
         if (stall_b !== 1'(c == 0 || c == 2)) begin
            mis++; $display("FAIL lat1_stall c=%0d got %b exp %b", c, stall_b, c == 0 || c == 2);
         end
         cmp++;
         if (done_b !== 1'(c == 1 || c == 3)) begin
            mis++; $display("FAIL lat1_done c=%0d got %b exp %b", c, done_b, c == 1 || c == 3);
         end
         if (c == 1 || c == 3) begin
            cmp++;
            if (dout_b !== pd[c/2]) begin
               mis++; $display("FAIL lat1_data c=%0d got %h exp %h", c, dout_b, pd[c/2]);
            end
         end
         @(posedge clk); #1;
         if (c == 1) addr_b = pa[1];
      end
      en_b = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         model_known[i] = 1'b0;
         model_mem[i]   = '0;
      end
      exp_dout   = '0;
      dout_known = 1'b0;
      test_reset;
      test_write_read_wrap;
      test_unaligned;
      test_busy_ignore;
      test_reset_mid_op;
      test_random;
      test_latency1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end

   // Absolute time limit so a stuck run still reports.
   initial begin
      #200000;
      $display("FAIL timeout compared=%0d", cmp);
      $fatal(1, "timeout");
   end

endmodule
